// File: rtl/ifu_fetch.sv
// ifu_fetch: multi-cycle instruction fetch stage with a valid/ready imem port and a valid/ready decode handoff.
// Ports:
//   i_clk, i_rst                   clock, synchronous active-high reset
//   i_npc, i_npc_valid             next PC strobe from the PC unit
//   o_imem_req_valid/i_imem_req_ready, o_imem_addr         fetch request
//   i_imem_rsp_valid/o_imem_rsp_ready, i_imem_rsp_data     fetch response
//   o_pc, o_instr, o_post_valid/i_post_ready               handoff to decode
//   o_perf_fetch_cnt, o_perf_stall_cnt                     only with IFU_PERF_CNT_EN defined
module ifu_fetch #(
  parameter int CPU_WIDTH = 32,
  parameter int INS_WIDTH = 32,
  parameter logic [CPU_WIDTH-1:0] PC_RESET = 32'h8000_0000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [CPU_WIDTH-1:0] i_npc,
  input  logic                 i_npc_valid,
  output logic                 o_imem_req_valid,
  input  logic                 i_imem_req_ready,
  output logic [CPU_WIDTH-1:0] o_imem_addr,
  input  logic                 i_imem_rsp_valid,
  output logic                 o_imem_rsp_ready,
  input  logic [INS_WIDTH-1:0] i_imem_rsp_data,
  output logic [CPU_WIDTH-1:0] o_pc,
  output logic [INS_WIDTH-1:0] o_instr,
  output logic                 o_post_valid,
`ifdef IFU_PERF_CNT_EN
  output logic [63:0]          o_perf_fetch_cnt,
  output logic [63:0]          o_perf_stall_cnt,
`endif
  input  logic                 i_post_ready
);
  localparam logic [1:0] S_REQ = 2'd0, S_RSP = 2'd1, S_OUT = 2'd2, S_WAIT = 2'd3;
  localparam logic [INS_WIDTH-1:0] NOP = INS_WIDTH'(32'h0000_0013);
  logic [1:0] state, state_nxt;
  logic [CPU_WIDTH-1:0] pc;
  logic [INS_WIDTH-1:0] instr;
  logic req_fire, rsp_fire, out_fire, take_npc;
  assign req_fire = (state == S_REQ) && i_imem_req_ready;
  assign rsp_fire = (state == S_RSP) && i_imem_rsp_valid;
  assign out_fire = (state == S_OUT) && i_post_ready;
  // npc is only consumed on the handoff cycle or while parked in S_WAIT
  assign take_npc = i_npc_valid && (out_fire || (state == S_WAIT));
  always_comb begin
    state_nxt = req_fire ? S_RSP :
                rsp_fire ? S_OUT :
                take_npc ? S_REQ :
                out_fire ? S_WAIT : state;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_REQ;
      pc    <= PC_RESET;
      instr <= NOP;
    end else begin
      state <= state_nxt;
      if (take_npc) pc <= {i_npc[CPU_WIDTH-1:2], 2'b00};
      if (rsp_fire) instr <= i_imem_rsp_data;
    end
  end
  assign o_imem_req_valid = (state == S_REQ);
  assign o_imem_rsp_ready = (state == S_RSP);
  assign o_post_valid     = (state == S_OUT);
  assign o_imem_addr      = pc;
  assign o_pc             = pc;
  assign o_instr          = instr;
`ifdef IFU_PERF_CNT_EN
  logic stall;
  assign stall = ((state == S_REQ) && !i_imem_req_ready) || ((state == S_RSP) && !i_imem_rsp_valid);
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_perf_fetch_cnt <= '0;
      o_perf_stall_cnt <= '0;
    end else begin
      if (rsp_fire) o_perf_fetch_cnt <= o_perf_fetch_cnt + 64'd1;
      if (stall) o_perf_stall_cnt <= o_perf_stall_cnt + 64'd1;
    end
  end
`endif
endmodule
